// File: rtl/frame_sequencer.sv
// frame_sequencer: ATTRACT / LIVE / FADE segment sequencer advanced once per vsync rising edge.
// Build macro NVG_FADE_BLINK_EN (optional) blinks the segment output with frame_cnt[3] while fading.
module frame_sequencer #(
  parameter int IDLE_FRAMES = 600,
  parameter int FADE_STEP   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic [7:0] ui_in,
  output logic [7:0] seg_en,
  output logic [6:0] scroll,
  output logic [1:0] mode,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    ATTRACT = 2'b00,
    LIVE    = 2'b01,
    FADE    = 2'b10
  } state_t;

  localparam logic [16:0] IDLE_LIM = 17'(IDLE_FRAMES);
  localparam logic [8:0]  STEP_LIM = 9'(FADE_STEP);

  state_t      state_reg;
  logic        vsync_q_reg;
  logic        frame_tick_reg;
  logic [10:0] frame_cnt_reg;
  logic [15:0] idle_cnt_reg;
  logic [7:0]  step_cnt_reg;
  logic [7:0]  latch_reg;
  logic [7:0]  seg_reg;

  logic        frame_evt;
  logic [10:0] frame_cnt_next;
  logic [16:0] idle_inc;
  logic [8:0]  step_inc;
  logic [7:0]  attract_pat;

  assign frame_evt      = vsync & ~vsync_q_reg;
  assign frame_cnt_next = frame_cnt_reg + 11'd1;
  assign idle_inc       = {1'b0, idle_cnt_reg} + 17'd1;
  assign step_inc       = {1'b0, step_cnt_reg} + 9'd1;
  assign attract_pat    = frame_cnt_next[8:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ATTRACT;
      vsync_q_reg    <= 1'b1;  // vsync already high at release must not count as an edge
      frame_tick_reg <= 1'b0;
      frame_cnt_reg  <= '0;
      idle_cnt_reg   <= '0;
      step_cnt_reg   <= '0;
      latch_reg      <= '0;
      seg_reg        <= '0;
    end else begin
      vsync_q_reg    <= vsync;
      frame_tick_reg <= frame_evt;
      if (frame_evt) begin
        frame_cnt_reg <= frame_cnt_next;
        case (state_reg)
          ATTRACT: begin
            if (ui_in != 8'h00) begin
              state_reg    <= LIVE;
              latch_reg    <= ui_in;
              seg_reg      <= ui_in;
              idle_cnt_reg <= '0;
            end else begin
              seg_reg <= attract_pat;
            end
          end
          LIVE: begin
            // A change to zero is still a change; LIVE only leaves through FADE.
            if (ui_in != latch_reg) begin
              latch_reg    <= ui_in;
              seg_reg      <= ui_in;
              idle_cnt_reg <= '0;
            end else begin
              if (idle_cnt_reg != 16'hFFFF)
                idle_cnt_reg <= idle_inc[15:0];
              if (idle_inc >= IDLE_LIM) begin
                state_reg    <= FADE;
                step_cnt_reg <= '0;
              end
            end
          end
          FADE: begin
            if (ui_in != latch_reg && ui_in != 8'h00) begin
              state_reg    <= LIVE;
              latch_reg    <= ui_in;
              seg_reg      <= ui_in;
              idle_cnt_reg <= '0;
            end else if (seg_reg == 8'h00) begin
              state_reg <= ATTRACT;
              seg_reg   <= attract_pat;
            end else if (step_inc == STEP_LIM) begin
              step_cnt_reg <= '0;
              seg_reg      <= {seg_reg[6:0], 1'b0};
            end else begin
              step_cnt_reg <= step_inc[7:0];
            end
          end
          default: begin
            state_reg <= ATTRACT;
            seg_reg   <= attract_pat;
          end
        endcase
      end
    end
  end

  assign scroll     = frame_cnt_reg[6:0];
  assign mode       = state_reg;
  assign frame_tick = frame_tick_reg;

`ifdef NVG_FADE_BLINK_EN
  // Blink gates only the output; the shift register keeps fading underneath.
  for (genvar gi = 0; gi < 8; gi++) begin : g_blink
    assign seg_en[gi] = seg_reg[gi] & ((state_reg != FADE) | frame_cnt_reg[3]);
  end
`else
  assign seg_en = seg_reg;
`endif

endmodule
